// File: rtl/cnn_pkg.sv
// Shared state encoding and sizing helper for the conv layer scheduler.
package cnn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_WB    = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_e;

  // Ceiling log2, never below 1 so a single-filter layer still gets an index bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Loadable up-counter with synchronous clear and a terminal-count compare.
module cycle_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_val_i,
  output logic             term_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // Clear has priority over load, load over increment.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign term_o = (count_q == term_val_i);

endmodule

// File: rtl/conv_filter_scheduler.sv
// Runs the shared kernel once per filter: select weights, reset, enable, write back.
module conv_filter_scheduler
  import cnn_pkg::*;
#(
  parameter int NUM_FILTERS    = 8,
  parameter int FILTER_IDX_BIT = clog2(NUM_FILTERS),
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [FILTER_IDX_BIT:0]   num_filters_cfg,
  output logic [FILTER_IDX_BIT-1:0] filter_sel,
  output logic                      kernel_reset,
  output logic                      kernel_enable,
  input  logic                      kernel_done,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [FILTER_IDX_BIT-1:0] wb_filter,
  output logic                      busy,
  output logic                      layer_done,
  output logic                      timeout_err
);

  localparam int CFG_W = FILTER_IDX_BIT + 1;
  localparam int WD_W  = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CFG_W-1:0] CFG_MAX = CFG_W'(NUM_FILTERS);

  state_e                    state_q, state_d;
  logic [FILTER_IDX_BIT-1:0] idx_q, idx_d;
  logic [CFG_W-1:0]          cfg_q, cfg_d;
  logic [CFG_W-1:0]          idx_next_s;
  logic                      terr_q, terr_d;
  logic                      load_term_s, wd_term_s;
  logic                      kreset_q, kenable_q, wbv_q, busy_q, ldone_q;

  // Each counter is held at zero outside its state, so it starts from 0 on entry.
  cycle_counter #(.WIDTH(4)) u_load_cnt (
    .clk_i(clock), .rst_i(reset), .clr_i(state_q != ST_LOAD),
    .load_i(1'b0), .load_val_i(4'd0), .en_i(1'b1),
    .term_val_i(4'(RESET_CYCLES - 1)), .term_o(load_term_s)
  );

  cycle_counter #(.WIDTH(WD_W)) u_watchdog (
    .clk_i(clock), .rst_i(reset), .clr_i(state_q != ST_RUN),
    .load_i(1'b0), .load_val_i('0), .en_i(1'b1),
    .term_val_i(WD_W'(TIMEOUT_CYCLES - 1)), .term_o(wd_term_s)
  );

  assign idx_next_s = CFG_W'(idx_q) + CFG_W'(1);

  // Layer sequencing; kernel_done outranks the watchdog in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cfg_d   = cfg_q;
    terr_d  = terr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          terr_d = 1'b0;
          if (num_filters_cfg == '0) begin
            state_d = ST_DONE;
          end else begin
            cfg_d   = (num_filters_cfg > CFG_MAX) ? CFG_MAX : num_filters_cfg;
            idx_d   = '0;
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_term_s) state_d = ST_RUN;
        else             state_d = ST_LOAD;
      end
      ST_RUN: begin
        if (kernel_done) begin
          state_d = ST_WB;
        end else if (wd_term_s) begin
          terr_d  = 1'b1;
          state_d = ST_ABORT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          if (idx_next_s < cfg_q) begin
            idx_d   = idx_next_s[FILTER_IDX_BIT-1:0];
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_WB;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, index and outputs; outputs are decoded from the next state so they align with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cfg_q     <= '0;
      terr_q    <= 1'b0;
      kreset_q  <= 1'b1;
      kenable_q <= 1'b0;
      wbv_q     <= 1'b0;
      busy_q    <= 1'b0;
      ldone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cfg_q     <= cfg_d;
      terr_q    <= terr_d;
      kreset_q  <= (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_ABORT);
      kenable_q <= (state_d == ST_RUN);
      wbv_q     <= (state_d == ST_WB);
      busy_q    <= (state_d != ST_IDLE);
      ldone_q   <= (state_d == ST_DONE);
    end
  end

  assign filter_sel    = idx_q;
  assign wb_filter     = idx_q;
  assign kernel_reset  = kreset_q;
  assign kernel_enable = kenable_q;
  assign wb_valid      = wbv_q;
  assign busy          = busy_q;
  assign layer_done    = ldone_q;
  assign timeout_err   = terr_q;

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Directed bench: phase-level reference model checked every cycle, plus per-layer literal totals.
module tb_conv_filter_scheduler;

  localparam int NF = 8;
  localparam int FB = 3;
  localparam int RC = 2;
  localparam int TO = 16;

  logic          clock       = 1'b0;
  logic          reset       = 1'b1;
  logic          start       = 1'b0;
  logic [FB:0]   cfg         = '0;
  logic          kernel_done = 1'b0;
  logic          wb_ready    = 1'b1;
  logic [FB-1:0] filter_sel, wb_filter;
  logic          kernel_reset, kernel_enable, wb_valid, busy, layer_done, timeout_err;

  conv_filter_scheduler #(
    .NUM_FILTERS(NF), .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_filters_cfg(cfg),
    .filter_sel(filter_sel), .kernel_reset(kernel_reset), .kernel_enable(kernel_enable),
    .kernel_done(kernel_done), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_filter(wb_filter), .busy(busy), .layer_done(layer_done), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Reference model: which phase the layer is in, how long it has left there, which filter.
  string m_phase  = "IDLE";
  int    m_filter = 0;
  int    m_total  = 0;
  int    m_left   = 0;
  int    m_ran    = 0;
  logic  m_err    = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_phase  <= "IDLE";
      m_filter <= 0;
      m_err    <= 1'b0;
    end else if (m_phase == "IDLE") begin
      if (start) begin
        m_err <= 1'b0;
        if (cfg == 0) begin
          m_phase <= "DONE";
        end else begin
          m_total  <= (int'(cfg) > NF) ? NF : int'(cfg);
          m_filter <= 0;
          m_left   <= RC;
          m_phase  <= "LOAD";
        end
      end
    end else if (m_phase == "LOAD") begin
      if (m_left == 1) begin
        m_phase <= "RUN";
        m_ran   <= 0;
      end else begin
        m_left <= m_left - 1;
      end
    end else if (m_phase == "RUN") begin
      if (kernel_done) begin
        m_phase <= "WB";
      end else if (m_ran + 1 == TO) begin
        m_err   <= 1'b1;
        m_phase <= "ABORT";
      end else begin
        m_ran <= m_ran + 1;
      end
    end else if (m_phase == "WB") begin
      if (wb_ready) begin
        if (m_filter + 1 < m_total) begin
          m_filter <= m_filter + 1;
          m_left   <= RC;
          m_phase  <= "LOAD";
        end else begin
          m_phase <= "DONE";
        end
      end
    end else begin
      m_phase <= "IDLE";
    end
  end

  int n_total = 0;
  int n_bad   = 0;

  int done_delay = 0, stall = 0, en_cnt = 0;
  int busy_cyc = 0, ld_cnt = 0, en_total = 0, wbv_cyc = 0, hs_cnt = 0, kr_run = 0;
  int hs_q[$];
  int lens[$];
  logic inj_start_wb = 1'b0, inj_done_load = 1'b0, prev_lk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_stats();
    busy_cyc = 0; ld_cnt = 0; en_total = 0; wbv_cyc = 0; hs_cnt = 0; kr_run = 0;
    hs_q.delete();
    lens.delete();
  endtask

  // One cycle: compare against the model, then play kernel and downstream buffer.
  task automatic tick();
    @(negedge clock);
    start = 1'b0;
    chk("kernel_reset", kernel_reset, (m_phase == "IDLE" || m_phase == "LOAD" || m_phase == "ABORT"));
    chk("kernel_enable", kernel_enable, (m_phase == "RUN"));
    chk("wb_valid", wb_valid, (m_phase == "WB"));
    chk("busy", busy, (m_phase != "IDLE"));
    chk("layer_done", layer_done, (m_phase == "DONE"));
    chk("timeout_err", timeout_err, m_err);
    if (m_phase == "LOAD" || m_phase == "RUN" || m_phase == "WB")
      chk("filter_sel", filter_sel, m_filter);
    if (m_phase == "WB")
      chk("wb_filter", wb_filter, m_filter);

    if (kernel_reset) begin
      kernel_done = 1'b0;
      en_cnt = 0;
    end else if (kernel_enable) begin
      en_cnt++;
      if (done_delay != 0 && en_cnt >= done_delay) kernel_done = 1'b1;
    end
    if (inj_done_load && kernel_reset && busy && !prev_lk) begin
      kernel_done = 1'b1;
      inj_done_load = 1'b0;
    end
    if (wb_valid && stall > 0) begin
      wb_ready = 1'b0;
      stall--;
    end else begin
      wb_ready = 1'b1;
    end
    if (inj_start_wb && wb_valid) begin
      start = 1'b1;
      inj_start_wb = 1'b0;
    end

    if (busy) busy_cyc++;
    if (layer_done) ld_cnt++;
    if (kernel_enable) en_total++;
    if (wb_valid) wbv_cyc++;
    if (wb_valid && wb_ready) begin
      hs_cnt++;
      hs_q.push_back(int'(wb_filter));
    end
    if (busy && kernel_reset) begin
      kr_run++;
    end else begin
      if (kernel_enable && kr_run != 0) lens.push_back(kr_run);
      kr_run = 0;
    end
    prev_lk = busy && kernel_reset;
  endtask

  task automatic run_layer(input int c, input int delay, input int stl, input int budget);
    clr_stats();
    cfg = 4'(c);
    done_delay = delay;
    stall = stl;
    start = 1'b1;
    tick();
    for (int i = 0; i < budget && busy; i++) tick();
    chk("layer_finished_in_budget", busy, 0);
  endtask

  task automatic chk_order(input int n);
    chk("wb_count", hs_q.size(), n);
    for (int i = 0; i < hs_q.size(); i++) chk("wb_order", hs_q[i], i);
  endtask

  initial begin
    int found;
    @(negedge clock);
    chk("rst_kernel_reset", kernel_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_filter_sel", filter_sel, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_kernel_enable", kernel_enable, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (2) tick();

    // Nominal: 3 filters x (2 load + 10 run + 1 wb) + 1 done
    run_layer(3, 10, 0, 200);
    chk_order(3);
    chk("nom_layer_done", ld_cnt, 1);
    chk("nom_busy_cycles", busy_cyc, 40);
    chk("nom_enable_cycles", en_total, 30);
    chk("nom_load_count", lens.size(), 3);
    foreach (lens[i]) chk("nom_load_len", lens[i], RC);

    // Backpressure: filter 0 waits 7 cycles for ready
    run_layer(2, 3, 7, 200);
    chk_order(2);
    chk("bp_valid_cycles", wbv_cyc, 9);
    chk("bp_busy_cycles", busy_cyc, 20);
    chk("bp_layer_done", ld_cnt, 1);

    // Watchdog: kernel never finishes
    run_layer(1, 0, 0, 200);
    chk("wd_enable_cycles", en_total, TO);
    chk("wd_busy_cycles", busy_cyc, 19);
    chk("wd_no_layer_done", ld_cnt, 0);
    chk("wd_no_wb", hs_cnt, 0);
    chk("wd_err_sticky", timeout_err, 1);

    // Zero filters right after: immediate done, error cleared
    run_layer(0, 2, 0, 20);
    chk("cfg0_layer_done", ld_cnt, 1);
    chk("cfg0_busy_cycles", busy_cyc, 1);
    chk("cfg0_no_enable", en_total, 0);
    chk("cfg0_err_cleared", timeout_err, 0);

    // Oversized config clamps to eight filters
    run_layer(15, 2, 0, 400);
    chk_order(8);
    chk("cfg15_layer_done", ld_cnt, 1);
    chk("cfg15_busy_cycles", busy_cyc, 41);

    // Ignored inputs: start during WB, kernel_done during LOAD
    inj_start_wb = 1'b1;
    inj_done_load = 1'b1;
    run_layer(3, 4, 3, 200);
    chk_order(3);
    chk("ign_layer_done", ld_cnt, 1);
    chk("ign_busy_cycles", busy_cyc, 25);
    chk("ign_start_injected", inj_start_wb, 0);
    chk("ign_done_injected", inj_done_load, 0);

    // Asynchronous reset in the middle of filter 1's RUN
    clr_stats();
    cfg = 4'd3;
    done_delay = 10;
    stall = 0;
    start = 1'b1;
    tick();
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick();
      if (kernel_enable && filter_sel == 3'd1) found = 1;
    end
    chk("arst_reached_run1", found, 1);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("arst_kernel_reset", kernel_reset, 1);
    chk("arst_kernel_enable", kernel_enable, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_filter_sel", filter_sel, 0);
    chk("arst_busy", busy, 0);
    #1 reset = 1'b0;
    tick();
    chk("arst_stays_idle", busy, 0);
    chk("arst_one_wb", hs_cnt, 1);
    chk("arst_no_layer_done", ld_cnt, 0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
